div_ctrl: RTL and testbench

//  EX-stage sequencer for DIV/DIVU, sitting directly upstream of the multi-cycle

---
 rtl/div_ctrl_if.sv | 32 +++
 rtl/div_ctrl.sv | 110 +++++++++++
 tb/tb_div_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX request, divider handshake and HI/LO write bundle for div_ctrl
interface div_ctrl_if;
    logic        req_i;
    logic        signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        signed_div_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    modport slave (
        input  req_i, signed_i, op1_i, op2_i, flush_i, div_result_i, div_ready_i,
        output div_start_o, div_annul_o, signed_div_o, div_op1_o, div_op2_o,
               stallreq_o, whilo_o, hi_o, lo_o, err_o
    );

    modport master (
        output req_i, signed_i, op1_i, op2_i, flush_i, div_result_i, div_ready_i,
        input  div_start_o, div_annul_o, signed_div_o, div_op1_o, div_op2_o,
               stallreq_o, whilo_o, hi_o, lo_o, err_o
    );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage DIV/DIVU sequencer: operand freeze, divider handshake, HI/LO write, watchdog
module div_ctrl #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DIV_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          sgn_q, sgn_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          whilo_q, whilo_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            sgn_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            sgn_q   <= sgn_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            err_q   <= err_d;
        end
    end

    // Operands are captured only in IDLE so the divider sees them frozen for the whole RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        sgn_d   = sgn_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_i && !bus.flush_i) begin
                    op1_d   = bus.op1_i;
                    op2_d   = bus.op2_i;
                    sgn_d   = bus.signed_i;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.div_ready_i) begin
                    hi_d    = bus.div_result_i[63:32];
                    lo_d    = bus.div_result_i[31:0];
                    whilo_d = 1'b1;
                    start_d = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.stallreq_o   = (state_q == S_IDLE && bus.req_i && !bus.flush_i) || (state_q == S_RUN);
    assign bus.div_annul_o  = bus.flush_i && (state_q == S_RUN);
    assign bus.div_start_o  = start_q;
    assign bus.signed_div_o = sgn_q;
    assign bus.div_op1_o    = op1_q;
    assign bus.div_op2_o    = op2_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.whilo_o      = whilo_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with a stub divider and arithmetic reference
module tb_div_ctrl;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    div_ctrl_if dif();

    div_ctrl #(.DIV_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          stub_lat = -1;
    bit          stray = 1'b0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Architectural DIV/DIVU result {remainder, quotient}; divide by zero yields 0/0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Stub divider: answers stub_lat cycles after start, reading the latched operands at that time.
    initial begin : stub
        int cnt;
        cnt = 0;
        dif.div_ready_i  = 1'b0;
        dif.div_result_i = '0;
        forever begin
            @(posedge clk);
            #1;
            dif.div_ready_i  = stray;
            dif.div_result_i = stray ? 64'hDEAD_BEEF_0BAD_F00D : 64'd0;
            if (rst && dif.div_start_o) begin
                if (cnt == stub_lat) begin
                    dif.div_ready_i  = 1'b1;
                    dif.div_result_i = ref_div(dif.div_op1_o, dif.div_op2_o, dif.signed_div_o);
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        bit   prev_w;
        exp_t e;
        prev_w = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && (dif.whilo_o || dif.err_o)) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: whilo=%b err=%b want no pulse", dif.whilo_o, dif.err_o);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_kind", 64'({dif.whilo_o, dif.err_o}), e.is_err ? 64'd1 : 64'd2);
                    if (!e.is_err) begin
                        check("hi", 64'(dif.hi_o), 64'(e.hi));
                        check("lo", 64'(dif.lo_o), 64'(e.lo));
                    end
                end
            end
            if (dif.whilo_o) check1("whilo_one_cycle", prev_w, 1'b0);
            prev_w = dif.whilo_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the block idle. mode: 0 normal, 1 flush at RUN cycle fk, 2 timeout.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int lat, input int mode, input int fk);
        logic [63:0] r;
        exp_t        e;
        int          n;
        r = ref_div(a, b, s);
        stub_lat = (mode == 2) ? -1 : lat;
        if (mode != 1) begin
            e.is_err = (mode == 2);
            e.hi     = (mode == 2) ? 32'd0 : r[63:32];
            e.lo     = (mode == 2) ? 32'd0 : r[31:0];
            sbq.push_back(e);
        end
        dif.req_i = 1'b1; dif.op1_i = a; dif.op2_i = b; dif.signed_i = s; dif.flush_i = 1'b0;
        #1 check1("stall_accept", dif.stallreq_o, 1'b1);
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (n == 3 && !dif.whilo_o && !dif.err_o) begin
                check("ops_latched", {dif.div_op1_o, dif.div_op2_o}, {a, b});
                dif.op1_i = $urandom; dif.op2_i = $urandom; dif.signed_i = ~s;
            end
            if (mode == 1 && n == fk + 1) begin
                dif.flush_i = 1'b1;
                #1;
                check1("annul", dif.div_annul_o, 1'b1);
                check1("start_before_flush", dif.div_start_o, 1'b1);
                step();
                dif.flush_i = 1'b0; dif.req_i = 1'b0;
                #1;
                check1("flush_start", dif.div_start_o, 1'b0);
                check1("flush_stall", dif.stallreq_o, 1'b0);
                check("flush_hilo", {dif.hi_o, dif.lo_o}, {last_hi, last_lo});
                return;
            end
            if (dif.whilo_o || dif.err_o) break;
            check1("stall_run", dif.stallreq_o, 1'b1);
        end
        dif.req_i = 1'b0;
        #1;
        check1("end_stall", dif.stallreq_o, 1'b0);
        check1("end_start", dif.div_start_o, 1'b0);
        check("latency", 64'(n), (mode == 2) ? 64'(TO + 1) : 64'(lat + 2));
        if (mode == 0) begin
            last_hi = r[63:32];
            last_lo = r[31:0];
        end
    endtask

    initial begin : stim
        logic [31:0] a, b;
        logic        s;
        int          fk;
        dif.req_i = 1'b0; dif.signed_i = 1'b0; dif.op1_i = '0; dif.op2_i = '0; dif.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({dif.div_start_o, dif.div_annul_o, dif.signed_div_o,
                              dif.stallreq_o, dif.whilo_o, dif.err_o}), 64'd0);
        check("rst_ops", {dif.div_op1_o, dif.div_op2_o}, 64'd0);
        check("rst_hilo", {dif.hi_o, dif.lo_o}, 64'd0);
        step();
        rst = 1'b1;

        step(); run_div(32'd100, 32'd7, 1'b0, 5, 0, 0);
        check("divu_100_7", {dif.hi_o, dif.lo_o}, {32'd2, 32'd14});
        step(); run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 8, 0, 0);
        check("div_neg7_2", {dif.hi_o, dif.lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        step(); run_div(32'd5, 32'd0, 1'b0, 3, 0, 0);
        step(); run_div(32'd1234, 32'd10, 1'b0, 30, 1, 10);
        step(); run_div(32'd77, 32'd3, 1'b0, 4, 1, 4);

        // Flush in IDLE blocks both the stall and the acceptance.
        step();
        dif.req_i = 1'b1; dif.flush_i = 1'b1;
        #1;
        check1("idle_flush_stall", dif.stallreq_o, 1'b0);
        check1("idle_flush_annul", dif.div_annul_o, 1'b0);
        step();
        check1("idle_flush_start", dif.div_start_o, 1'b0);
        dif.req_i = 1'b0; dif.flush_i = 1'b0;

        @(negedge clk) stray = 1'b1;
        @(negedge clk) stray = 1'b0;
        step();
        check("stray_ready_hilo", {dif.hi_o, dif.lo_o}, {last_hi, last_lo});

        step(); run_div(32'd50, 32'd5, 1'b0, 0, 2, 0);

        step(); run_div(32'd9, 32'd2, 1'b0, 2, 0, 0);
        check("b2b_first", {dif.hi_o, dif.lo_o}, {32'd1, 32'd4});
        dif.req_i = 1'b1; dif.op1_i = 32'd9; dif.op2_i = 32'd4; dif.signed_i = 1'b0;
        step();
        check1("b2b_gap_start", dif.div_start_o, 1'b0);
        check1("b2b_gap_stall", dif.stallreq_o, 1'b1);
        run_div(32'd9, 32'd4, 1'b0, 2, 0, 0);
        check("b2b_second", {dif.hi_o, dif.lo_o}, {32'd1, 32'd2});

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
            s = 1'($urandom_range(0, 1));
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            step();
            if ($urandom_range(0, 9) == 0) begin
                fk = $urandom_range(0, 10);
                run_div(a, b, s, fk + $urandom_range(0, 5), 1, fk);
            end else begin
                run_div(a, b, s, $urandom_range(0, 36), 0, 0);
            end
        end

        // Asynchronous reset in the middle of a signed divide.
        step();
        stub_lat = -1;
        dif.req_i = 1'b1; dif.op1_i = 32'h1234_5678; dif.op2_i = 32'd3; dif.signed_i = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        dif.req_i = 1'b0;
        #1;
        check("midrun_rst_ctl", 64'({dif.div_start_o, dif.div_annul_o, dif.signed_div_o,
                                     dif.stallreq_o, dif.whilo_o, dif.err_o}), 64'd0);
        check("midrun_rst_ops", {dif.div_op1_o, dif.div_op2_o}, 64'd0);
        check("midrun_rst_hilo", {dif.hi_o, dif.lo_o}, 64'd0);
        last_hi = '0; last_lo = '0;
        step();
        rst = 1'b1;
        step(); run_div(32'd1000, 32'd33, 1'b0, 6, 0, 0);
        check("post_rst_div", {dif.hi_o, dif.lo_o}, {32'd10, 32'd30});

        repeat (3) step();
        check("queue_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
